autosym_sweep_ctrl: RTL

//  Sequencer that time-shares one combinational single-output PLA function block (N_IN inputs -> 1 output).

---
 rtl/autosym_sweep_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/autosym_sweep_ctrl.sv
// autosym_sweep_ctrl
// Time-shares one single-output combinational function block. It sweeps every
// input vector v, counts the onset size of f, and checks whether
// f(v) == f(v ^ alpha) holds for all v (autosymmetry under alpha).
// Each vector takes two cycles: EVAL_A drives v, EVAL_B drives v ^ alpha.
module autosym_sweep_ctrl #(
  parameter int N_IN  = 8,
  parameter int CNT_W = N_IN + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [N_IN-1:0]  i_alpha,
  output logic             o_busy,
  output logic             o_done,
  output logic [N_IN-1:0]  o_f_x,
  input  logic             i_f_y,
  output logic [CNT_W-1:0] o_onset_cnt,
  output logic             o_mismatch,
  output logic [N_IN-1:0]  o_first_bad,
  output logic             o_is_autosym
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL_A = 2'd1,
    S_EVAL_B = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [N_IN-1:0]  V_ZERO = {N_IN{1'b0}};
  localparam logic [N_IN-1:0]  V_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0]  V_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state,     w_state;
  logic [N_IN-1:0]   r_alpha,     w_alpha;
  logic [N_IN-1:0]   r_v,         w_v;
  logic              r_y_a,       w_y_a;
  logic [N_IN-1:0]   r_f_x,       w_f_x;
  logic              r_busy,      w_busy;
  logic              r_done,      w_done;
  logic [CNT_W-1:0]  r_onset_cnt, w_onset_cnt;
  logic              r_mismatch,  w_mismatch;
  logic [N_IN-1:0]   r_first_bad, w_first_bad;
  logic              r_is_autosym, w_is_autosym;

  // Next-state and next-output logic; every value holds unless a state updates it.
  always_comb begin
    w_state      = r_state;
    w_alpha      = r_alpha;
    w_v          = r_v;
    w_y_a        = r_y_a;
    w_f_x        = r_f_x;
    w_busy       = r_busy;
    w_done       = 1'b0;
    w_onset_cnt  = r_onset_cnt;
    w_mismatch   = r_mismatch;
    w_first_bad  = r_first_bad;
    w_is_autosym = r_is_autosym;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_alpha      = i_alpha;
          w_onset_cnt  = C_ZERO;
          w_mismatch   = 1'b0;
          w_first_bad  = V_ZERO;
          w_is_autosym = 1'b0;
          w_v          = V_ZERO;
          w_f_x        = V_ZERO;
          w_busy       = 1'b1;
          w_state      = S_EVAL_A;
        end else begin
          w_state      = S_IDLE;
        end
      end
      S_EVAL_A: begin
        // f_x currently carries v; remember f(v) and present v ^ alpha next.
        w_y_a = i_f_y;
        if (i_f_y) begin
          w_onset_cnt = r_onset_cnt + C_ONE;
        end else begin
          w_onset_cnt = r_onset_cnt;
        end
        w_f_x   = r_v ^ r_alpha;
        w_state = S_EVAL_B;
      end
      S_EVAL_B: begin
        // Only the first (smallest) mismatching v is recorded.
        if ((i_f_y != r_y_a) && !r_mismatch) begin
          w_mismatch  = 1'b1;
          w_first_bad = r_v;
        end else begin
          w_mismatch  = r_mismatch;
          w_first_bad = r_first_bad;
        end
        // Exit on the all-ones vector so v never wraps inside a sweep.
        if (r_v == V_LAST) begin
          w_f_x        = V_ZERO;
          w_done       = 1'b1;
          w_is_autosym = ~w_mismatch;
          w_state      = S_DONE;
        end else begin
          w_v          = r_v + V_ONE;
          w_f_x        = r_v + V_ONE;
          w_state      = S_EVAL_A;
        end
      end
      S_DONE: begin
        // A start seen here is deliberately dropped.
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end
      default: begin
        w_busy  = 1'b0;
        w_f_x   = V_ZERO;
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset to the idle values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_alpha      <= V_ZERO;
      r_v          <= V_ZERO;
      r_y_a        <= 1'b0;
      r_f_x        <= V_ZERO;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_onset_cnt  <= C_ZERO;
      r_mismatch   <= 1'b0;
      r_first_bad  <= V_ZERO;
      r_is_autosym <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_alpha      <= w_alpha;
      r_v          <= w_v;
      r_y_a        <= w_y_a;
      r_f_x        <= w_f_x;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_onset_cnt  <= w_onset_cnt;
      r_mismatch   <= w_mismatch;
      r_first_bad  <= w_first_bad;
      r_is_autosym <= w_is_autosym;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_f_x        = r_f_x;
  assign o_onset_cnt  = r_onset_cnt;
  assign o_mismatch   = r_mismatch;
  assign o_first_bad  = r_first_bad;
  assign o_is_autosym = r_is_autosym;

endmodule
